iec_line_filter: RTL and testbench

Parametrised multi-channel input conditioner for asynchronous serial-bus lines (ATN, CLK, DATA, FCLK, RESET) entering a drive core. It is the successor to the per-line two-flop synchroniser used by the drive models. It adds configurable synchroniser depth, a stability filter whose length is counted in clock-enable ticks, registered edge strobes, and sticky per-channel change flags with clear. One instance replaces a bank of single-line synchronisers inside a drive top level.

---
 rtl/iec_line_filter.sv | 96 +++++++++
 tb/tb_iec_line_filter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/iec_line_filter.sv
`default_nettype none
// ============================================================================
//  Module   : iec_line_filter
//  Purpose  : Multi-channel conditioner for asynchronous serial-bus lines.
//             Each channel runs a synchroniser chain, a ce-paced stability
//             filter, registered rise/fall strobes and a sticky change flag.
//  Revision : 1.0  initial release
// ============================================================================
module iec_line_filter #(
   parameter int                    CHANNELS  = 4,
   parameter int                    STAGES    = 2,
   parameter int                    STABLE    = 1,
   parameter logic [CHANNELS-1:0]   RESET_VAL = '1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ce,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] evt,
   input  logic [CHANNELS-1:0] evt_clr
);

   // Counter only needs to reach STABLE-1; keep at least one bit.
   localparam int             CNT_W   = (STABLE > 1) ? $clog2(STABLE) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);

   generate
      for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
         logic [STAGES-1:0] sync_q, sync_d;
         logic              prev_q, prev_d;
         logic [CNT_W-1:0]  cnt_q,  cnt_d;
         logic              out_q,  out_d;
         logic              rise_q, rise_d;
         logic              fall_q, fall_d;
         logic              evt_q,  evt_d;
         logic              s;

         // Last synchroniser stage is the sample the filter works on.
         assign s = sync_q[STAGES-1];

         // Next-state logic: shift the synchroniser every clk, filter on ce.
         always_comb begin
            sync_d = {sync_q[STAGES-2:0], in[ch]};
            prev_d = prev_q;
            cnt_d  = cnt_q;
            out_d  = out_q;
            if (ce) begin
               prev_d = s;
               if (s != prev_q) begin
                  cnt_d = '0;
               end else if (cnt_q == CNT_MAX) begin
                  out_d = s;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            // Strobes and the sticky flag are derived from the out update so
            // they land in the same cycle the filtered level moves.
            rise_d = out_d & ~out_q;
            fall_d = ~out_d & out_q;
            evt_d  = (evt_q & ~evt_clr[ch]) | (out_d ^ out_q);
         end

         // State registers; reset loads the idle bus level into sample state.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync_q <= {STAGES{RESET_VAL[ch]}};
               prev_q <= RESET_VAL[ch];
               cnt_q  <= '0;
               out_q  <= RESET_VAL[ch];
               rise_q <= 1'b0;
               fall_q <= 1'b0;
               evt_q  <= 1'b0;
            end else begin
               sync_q <= sync_d;
               prev_q <= prev_d;
               cnt_q  <= cnt_d;
               out_q  <= out_d;
               rise_q <= rise_d;
               fall_q <= fall_d;
               evt_q  <= evt_d;
            end
         end

         assign out[ch]  = out_q;
         assign rise[ch] = rise_q;
         assign fall[ch] = fall_q;
         assign evt[ch]  = evt_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_iec_line_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iec_line_filter
//  Purpose  : Directed self-checking bench for iec_line_filter
//             (CHANNELS=4, STAGES=2, STABLE=3, RESET_VAL=4'hF).
//  Revision : 1.0  initial release
// ============================================================================
module tb_iec_line_filter;

   logic       clk;
   logic       reset;
   logic       ce;
   logic [3:0] line_in;
   logic [3:0] line_out;
   logic [3:0] rise;
   logic [3:0] fall;
   logic [3:0] evt;
   logic [3:0] evt_clr;

   int n_cmp;
   int n_bad;

   iec_line_filter #(
      .CHANNELS  (4),
      .STAGES    (2),
      .STABLE    (3),
      .RESET_VAL (4'hF)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .ce      (ce),
      .in      (line_in),
      .out     (line_out),
      .rise    (rise),
      .fall    (fall),
      .evt     (evt),
      .evt_clr (evt_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reset with lines held low; after release the low level takes 6 edges
   // (edge index 5 counting from 0) to reach out.
   task automatic test_reset;
      reset = 1'b1; ce = 1'b1; line_in = 4'h0; evt_clr = 4'h0;
      step(3);
      n_cmp++; if (line_out !== 4'hF) begin n_bad++; $display("FAIL reset_out: got %h want %h", line_out, 4'hF); end
      n_cmp++; if (rise !== 4'h0) begin n_bad++; $display("FAIL reset_rise: got %h want %h", rise, 4'h0); end
      n_cmp++; if (fall !== 4'h0) begin n_bad++; $display("FAIL reset_fall: got %h want %h", fall, 4'h0); end
      n_cmp++; if (evt !== 4'h0) begin n_bad++; $display("FAIL reset_evt: got %h want %h", evt, 4'h0); end
      reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step(1);
         n_cmp++; if (line_out !== ((i >= 5) ? 4'h0 : 4'hF)) begin n_bad++; $display("FAIL release_out[%0d]: got %h want %h", i, line_out, (i >= 5) ? 4'h0 : 4'hF); end
         n_cmp++; if (fall !== ((i == 5) ? 4'hF : 4'h0)) begin n_bad++; $display("FAIL release_fall[%0d]: got %h want %h", i, fall, (i == 5) ? 4'hF : 4'h0); end
         n_cmp++; if (rise !== 4'h0) begin n_bad++; $display("FAIL release_rise[%0d]: got %h want %h", i, rise, 4'h0); end
         n_cmp++; if (evt !== ((i >= 5) ? 4'hF : 4'h0)) begin n_bad++; $display("FAIL release_evt[%0d]: got %h want %h", i, evt, (i >= 5) ? 4'hF : 4'h0); end
      end
   endtask

   // Short low pulse on line 1 is rejected; a 4-cycle pulse passes as a
   // 4-cycle low on out[1].
   task automatic test_glitch;
      logic [3:0] exp_out;
      line_in = 4'hF;
      step(6);
      evt_clr = 4'hF;
      step(1);
      evt_clr = 4'h0;
      n_cmp++; if (line_out !== 4'hF) begin n_bad++; $display("FAIL glitch_setup_out: got %h want %h", line_out, 4'hF); end
      n_cmp++; if (evt !== 4'h0) begin n_bad++; $display("FAIL glitch_setup_evt: got %h want %h", evt, 4'h0); end

      line_in[1] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i == 3) line_in[1] = 1'b1;
         step(1);
         n_cmp++; if (line_out !== 4'hF) begin n_bad++; $display("FAIL short_out[%0d]: got %h want %h", i, line_out, 4'hF); end
         n_cmp++; if ((rise | fall) !== 4'h0) begin n_bad++; $display("FAIL short_strobe[%0d]: got %h want %h", i, rise | fall, 4'h0); end
      end

      line_in[1] = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (i == 4) line_in[1] = 1'b1;
         step(1);
         exp_out = (i >= 5 && i < 9) ? 4'hD : 4'hF;
         n_cmp++; if (line_out !== exp_out) begin n_bad++; $display("FAIL long_out[%0d]: got %h want %h", i, line_out, exp_out); end
         n_cmp++; if (fall !== ((i == 5) ? 4'h2 : 4'h0)) begin n_bad++; $display("FAIL long_fall[%0d]: got %h want %h", i, fall, (i == 5) ? 4'h2 : 4'h0); end
         n_cmp++; if (rise !== ((i == 9) ? 4'h2 : 4'h0)) begin n_bad++; $display("FAIL long_rise[%0d]: got %h want %h", i, rise, (i == 9) ? 4'h2 : 4'h0); end
      end
   endtask

   // ce on every 4th edge (3,7,11,15). s on line 0 changes at edge 1, so the
   // 4th tick after that is edge 15.
   task automatic test_sparse_ce;
      for (int i = 0; i < 24; i++) begin
         ce = ((i % 4) == 3);
         if (i == 0) line_in[0] = 1'b0;
         step(1);
         n_cmp++; if (line_out !== ((i >= 15) ? 4'hE : 4'hF)) begin n_bad++; $display("FAIL sparse_out[%0d]: got %h want %h", i, line_out, (i >= 15) ? 4'hE : 4'hF); end
         n_cmp++; if (fall !== ((i == 15) ? 4'h1 : 4'h0)) begin n_bad++; $display("FAIL sparse_fall[%0d]: got %h want %h", i, fall, (i == 15) ? 4'h1 : 4'h0); end
         n_cmp++; if (rise !== 4'h0) begin n_bad++; $display("FAIL sparse_rise[%0d]: got %h want %h", i, rise, 4'h0); end
      end
      ce = 1'b1;
   endtask

   // Sticky flag clear alone, and clear colliding with a new change.
   task automatic test_evt_clr;
      evt_clr = 4'hF;
      step(1);
      evt_clr = 4'h0;
      n_cmp++; if (evt !== 4'h0) begin n_bad++; $display("FAIL evt_clear_all: got %h want %h", evt, 4'h0); end
      line_in[2] = 1'b0;
      step(6);
      n_cmp++; if (line_out !== 4'hA) begin n_bad++; $display("FAIL evt_out_a: got %h want %h", line_out, 4'hA); end
      n_cmp++; if (evt !== 4'h4) begin n_bad++; $display("FAIL evt_set: got %h want %h", evt, 4'h4); end
      evt_clr = 4'h4;
      step(1);
      evt_clr = 4'h0;
      n_cmp++; if (evt !== 4'h0) begin n_bad++; $display("FAIL evt_clr_alone: got %h want %h", evt, 4'h0); end
      line_in[2] = 1'b1;
      step(6);
      n_cmp++; if (evt !== 4'h4) begin n_bad++; $display("FAIL evt_reset_again: got %h want %h", evt, 4'h4); end
      line_in[2] = 1'b0;
      step(5);
      evt_clr = 4'h4;
      step(1);
      evt_clr = 4'h0;
      n_cmp++; if (fall !== 4'h4) begin n_bad++; $display("FAIL evt_collide_fall: got %h want %h", fall, 4'h4); end
      n_cmp++; if (evt !== 4'h4) begin n_bad++; $display("FAIL evt_collide_set_wins: got %h want %h", evt, 4'h4); end
      step(1);
      n_cmp++; if (evt !== 4'h4) begin n_bad++; $display("FAIL evt_sticky: got %h want %h", evt, 4'h4); end
      evt_clr = 4'h4;
      step(1);
      evt_clr = 4'h0;
      n_cmp++; if (evt !== 4'h0) begin n_bad++; $display("FAIL evt_final_clr: got %h want %h", evt, 4'h0); end
   endtask

   // Mid-run reset: out snaps to idle high at once, then relearns the low level.
   task automatic test_reset_midrun;
      line_in = 4'h0;
      step(6);
      evt_clr = 4'hF;
      step(1);
      evt_clr = 4'h0;
      n_cmp++; if (line_out !== 4'h0) begin n_bad++; $display("FAIL mid_pre_out: got %h want %h", line_out, 4'h0); end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++; if (line_out !== 4'hF) begin n_bad++; $display("FAIL mid_async_out: got %h want %h", line_out, 4'hF); end
      n_cmp++; if ((rise | fall | evt) !== 4'h0) begin n_bad++; $display("FAIL mid_async_flags: got %h want %h", rise | fall | evt, 4'h0); end
      step(1);
      reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step(1);
         n_cmp++; if (line_out !== ((i >= 5) ? 4'h0 : 4'hF)) begin n_bad++; $display("FAIL mid_out[%0d]: got %h want %h", i, line_out, (i >= 5) ? 4'h0 : 4'hF); end
         n_cmp++; if (fall !== ((i == 5) ? 4'hF : 4'h0)) begin n_bad++; $display("FAIL mid_fall[%0d]: got %h want %h", i, fall, (i == 5) ? 4'hF : 4'h0); end
         n_cmp++; if (rise !== 4'h0) begin n_bad++; $display("FAIL mid_rise[%0d]: got %h want %h", i, rise, 4'h0); end
      end
   endtask

   // All channels change together; per-bit strobes follow the direction.
   task automatic test_parallel;
      logic [3:0] pats [3];
      logic [3:0] old_v;
      logic [3:0] new_v;
      pats[0] = 4'hF; pats[1] = 4'h5; pats[2] = 4'hA;
      old_v = 4'h0;
      for (int p = 0; p < 3; p++) begin
         new_v   = pats[p];
         line_in = new_v;
         for (int i = 0; i < 7; i++) begin
            step(1);
            n_cmp++; if (line_out !== ((i >= 5) ? new_v : old_v)) begin n_bad++; $display("FAIL par_out[%0d.%0d]: got %h want %h", p, i, line_out, (i >= 5) ? new_v : old_v); end
            n_cmp++; if (rise !== ((i == 5) ? (new_v & ~old_v) : 4'h0)) begin n_bad++; $display("FAIL par_rise[%0d.%0d]: got %h want %h", p, i, rise, (i == 5) ? (new_v & ~old_v) : 4'h0); end
            n_cmp++; if (fall !== ((i == 5) ? (~new_v & old_v) : 4'h0)) begin n_bad++; $display("FAIL par_fall[%0d.%0d]: got %h want %h", p, i, fall, (i == 5) ? (~new_v & old_v) : 4'h0); end
         end
         old_v = new_v;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1; ce = 1'b1; line_in = 4'h0; evt_clr = 4'h0;
      test_reset();
      test_glitch();
      test_sparse_ce();
      test_evt_clr();
      test_reset_midrun();
      test_parallel();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
